subtractor_64_bit_seq: RTL and testbench
========================================

Name: subtractor_64_bit_seq

Overview:
- Multi-cycle unsigned subtractor: diff = input1 - input2, WIDTH bits, with borrow-out.
- Processes CHUNK bits per clock, LSB chunk first; the borrow ripples between chunks through a register.
- Start/done handshake. Sits beside the 64-bit adder in the datapath and is used where a full-width combinational borrow chain is too slow.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- input1  input  WIDTH  minuend; sampled on the accepted start edge
- input2  input  WIDTH  subtrahend; sampled on the accepted start edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  WIDTH  result (input1 - input2) mod 2^WIDTH
- borrow  output  1  1 when input1 < input2 (unsigned)

Behaviour:
- Reset (rst_n=0, asynchronous): FSM=IDLE; busy=0, done=0, diff=0, borrow=0; operand registers, chunk counter and borrow register cleared. Applies immediately, including mid-operation. The aborted operation produces no done.
- FSM states: IDLE, BUSY.
  - IDLE with start=1 at edge k: latch input1/input2, clear borrow register and counter, go to BUSY. busy=1 after edge k.
  - BUSY, edges k+1..k+N: at edge k+j, compute chunk j-1: bits [(j-1)*CHUNK +: CHUNK] = a - b - borrow_reg. Write the result into diff and update borrow_reg with the chunk borrow.
  - At edge k+N: FSM returns to IDLE, busy=0, done=1, borrow = final chunk borrow.
- Latency: done is high in the cycle after edge k+N, i.e. N cycles after start is sampled (8 for the defaults).
- done is high for exactly one cycle. diff and borrow hold their values until the next accepted start.
- During BUSY, diff shows partial results. It is valid only from the done cycle onward.
- start while busy=1 is ignored: no queuing, and operands are not re-sampled.
- Back-to-back: start=1 during the done cycle is accepted, because the FSM is already in IDLE. On that edge done drops to 0 and busy rises.
- Operand changes after the accepted start have no effect on the result.
- Boundary cases:
  - 0 - 0 gives diff=0, borrow=0.
  - 0 - 1 wraps to all-ones with borrow=1.
  - x - x gives 0 with borrow=0.
- Chunk arithmetic uses CHUNK+1 bits. The MSB of (a - b - bin) is the chunk borrow.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined: adds output port overflow (output, 1 bit), meaning signed two's-complement overflow.
  - overflow = (input1[MSB] != input2[MSB]) && (diff[MSB] != input1[MSB]), registered at edge k+N together with borrow.
  - Reset value 0. Holds until the next accepted start.
- Not defined: the overflow port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> busy=0, done=0, diff=0, borrow=0; no activity without start.
- Basic: input1=64'h0000_0000_0000_1000, input2=64'h1 -> done exactly 8 cycles after start; diff=64'h0FFF, borrow=0.
- Full borrow ripple: input1=0, input2=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, borrow=1. With SUB_OVERFLOW_EN: overflow=0.
- Signed overflow (SUB_OVERFLOW_EN): input1=64'h8000_0000_0000_0000, input2=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, borrow=0, overflow=1.
- Handshake:
  - Pulse start again at cycles 3 and 5 of a busy operation with different operands -> ignored; the first result is unchanged.
  - Start during the done cycle with input1=5, input2=5 -> accepted; second done 8 cycles later with diff=0, borrow=0.
- Reset mid-operation: assert rst_n=0 at cycle 4 of BUSY -> outputs go to 0 immediately and no done appears. A new start after release completes normally.

Source files
------------

// File: rtl/subtractor_64_bit_seq.sv
// Multi-cycle unsigned subtractor: diff = input1 - input2, CHUNK bits per clock, LSB chunk first.
// Optional macro SUB_OVERFLOW_EN adds a registered signed-overflow output.
module subtractor_64_bit_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] cnt;
  logic             brw;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sub;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] diff_nxt;
  logic             last;

  // The extra MSB of the CHUNK+1 bit result is the borrow out of this chunk.
  function automatic logic [CHUNK:0] chunk_sub(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             bin);
    chunk_sub = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  endfunction

  always_comb begin
    sh       = 32'(cnt) * 32'(CHUNK);
    a_c      = CHUNK'(op_a >> sh);
    b_c      = CHUNK'(op_b >> sh);
    sub      = chunk_sub(a_c, b_c, brw);
    mask     = WIDTH'({CHUNK{1'b1}}) << sh;
    diff_nxt = (diff & ~mask) | (WIDTH'(sub[CHUNK-1:0]) << sh);
    last     = (cnt == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= input1;
            op_b  <= input2;
            cnt   <= '0;
            brw   <= 1'b0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          diff <= diff_nxt;
          brw  <= sub[CHUNK];
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            borrow   <= sub[CHUNK];
`ifdef SUB_OVERFLOW_EN
            overflow <= (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                        (diff_nxt[WIDTH-1] != op_a[WIDTH-1]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_64_bit_seq.sv
// Directed-vector bench for subtractor_64_bit_seq (default 64-bit, 8-bit chunks).
module tb_subtractor_64_bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] input1 = '0;
  logic [63:0] input2 = '0;
  logic        busy;
  logic        done;
  logic [63:0] diff;
  logic        borrow;
`ifdef SUB_OVERFLOW_EN
  logic        overflow;
`endif

  int total = 0;
  int bad   = 0;

  subtractor_64_bit_seq #(.WIDTH(64), .CHUNK(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus only: issue a start, scramble operands afterwards, return done latency (-1 on timeout).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, output int lat);
    @(negedge clk);
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    input1 = ~a;
    input2 = ~b;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int act;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, borrow} !== 3'b000 || diff !== 64'h0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
    end
`ifdef SUB_OVERFLOW_EN
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0) act++;
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL idle_no_activity: got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_op(64'h0000_0000_0000_1000, 64'h1, lat);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    total++;
    if (diff !== 64'h0000_0000_0000_0FFF || borrow !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got diff=%h borrow=%b want 0000000000000fff 0", diff, borrow);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || diff !== 64'h0000_0000_0000_0FFF) begin
      bad++;
      $display("FAIL done_one_cycle_hold: got done=%b diff=%h want 0 0000000000000fff", done, diff);
    end
  endtask

  task automatic test_boundaries();
    int lat;
    run_op(64'h0, 64'h1, lat);
    total++;
    if (lat !== 8 || diff !== 64'hFFFF_FFFF_FFFF_FFFF || borrow !== 1'b1) begin
      bad++;
      $display("FAIL ripple_0_minus_1: got lat=%0d diff=%h borrow=%b want 8 ffffffffffffffff 1", lat, diff, borrow);
    end
`ifdef SUB_OVERFLOW_EN
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ripple_overflow: got %b want 0", overflow);
    end
`endif
    run_op(64'h0, 64'h0, lat);
    total++;
    if (diff !== 64'h0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL zero_minus_zero: got diff=%h borrow=%b want 0 0", diff, borrow);
    end
    run_op(64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678, lat);
    total++;
    if (diff !== 64'h0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL x_minus_x: got diff=%h borrow=%b want 0 0", diff, borrow);
    end
    run_op(64'h0123_4567_89AB_CDEF, 64'h0F00_0000_0000_00F0, lat);
    total++;
    if (diff !== 64'hF223_4567_89AB_CCFF || borrow !== 1'b1) begin
      bad++;
      $display("FAIL mixed_borrow: got diff=%h borrow=%b want f223456789abccff 1", diff, borrow);
    end
  endtask

`ifdef SUB_OVERFLOW_EN
  task automatic test_overflow();
    int lat;
    run_op(64'h8000_0000_0000_0000, 64'h1, lat);
    total++;
    if (diff !== 64'h7FFF_FFFF_FFFF_FFFF || borrow !== 1'b0 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL signed_overflow: got diff=%h borrow=%b ovf=%b want 7fffffffffffffff 0 1", diff, borrow, overflow);
    end
  endtask
`endif

  task automatic test_ignore_start();
    int lat;
    int busy_low;
    @(negedge clk);
    input1 = 64'd100;
    input2 = 64'd1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    busy_low = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start  = (i == 3 || i == 5);
      input1 = 64'd7;
      input2 = 64'd9;
      @(posedge clk);
      #1;
      if (i < 8 && busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    total++;
    if (lat !== 8 || busy_low !== 0) begin
      bad++;
      $display("FAIL ignore_start_timing: got lat=%0d busy_low=%0d want 8 0", lat, busy_low);
    end
    total++;
    if (diff !== 64'd99 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_result: got diff=%h borrow=%b want 0000000000000063 0", diff, borrow);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(64'h20, 64'h3, lat);
    total++;
    if (lat !== 8 || diff !== 64'h1D) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d diff=%h want 8 000000000000001d", lat, diff);
    end
    input1 = 64'd5;
    input2 = 64'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done, busy);
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== 8 || diff !== 64'h0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d diff=%h borrow=%b want 8 0 0", lat, diff, borrow);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    @(negedge clk);
    input1 = 64'hFFFF;
    input2 = 64'h1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, borrow} !== 3'b000 || diff !== 64'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_no_done: got %0d active cycles want 0", seen);
    end
    run_op(64'h10, 64'h20, lat);
    total++;
    if (lat !== 8 || diff !== 64'hFFFF_FFFF_FFFF_FFF0 || borrow !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_op: got lat=%0d diff=%h borrow=%b want 8 fffffffffffffff0 1", lat, diff, borrow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
`ifdef SUB_OVERFLOW_EN
    test_overflow();
`endif
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
